// File: rtl/sum_window_avg_pkg.sv
// rtl/sum_window_avg_pkg.sv - shared widths, constants and window-phase type for the sum window averager
package sum_window_avg_pkg;

    localparam int SAMPLE_W         = 8;
    localparam int LOG2_WIN_DEFAULT = 2;
    localparam int SUM_W            = SAMPLE_W + LOG2_WIN_DEFAULT;

    localparam int              WIN_CNT_W   = 16;
    localparam logic [15:0]     WIN_CNT_MAX = 16'hFFFF;

    typedef enum logic {
        PH_FILL = 1'b0,
        PH_LAST = 1'b1
    } win_phase_e;

    function automatic logic [WIN_CNT_W-1:0] sat_inc(input logic [WIN_CNT_W-1:0] v);
        return (v == WIN_CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sum_window_avg_if.sv
// rtl/sum_window_avg_if.sv - sample input and window-result output handshakes
interface sum_window_avg_if
    import sum_window_avg_pkg::*;
#(
    parameter int DATA_W   = SAMPLE_W,
    parameter int LOG2_WIN = LOG2_WIN_DEFAULT
);
    logic                         in_valid;
    logic                         in_ready;
    logic [DATA_W-1:0]            in_data;
    logic                         out_valid;
    logic                         out_ready;
    logic [DATA_W+LOG2_WIN-1:0]   out_sum;
    logic [DATA_W-1:0]            out_avg;
    logic [DATA_W-1:0]            out_max;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, out_avg, out_max
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, out_avg, out_max
    );
endinterface

// File: rtl/sum_window_avg_win_result_reg.sv
// rtl/sum_window_avg_win_result_reg.sv - window result holding register with drain accounting
module win_result_reg
    import sum_window_avg_pkg::*;
#(
    parameter int DATA_W   = SAMPLE_W,
    parameter int LOG2_WIN = LOG2_WIN_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load_i,
    input  logic [DATA_W+LOG2_WIN-1:0]   sum_i,
    input  logic [DATA_W-1:0]            max_i,
    input  logic                         out_ready_i,
    output logic                         out_valid_o,
    output logic [DATA_W+LOG2_WIN-1:0]   out_sum_o,
    output logic [DATA_W-1:0]            out_avg_o,
    output logic [DATA_W-1:0]            out_max_o,
    output logic [WIN_CNT_W-1:0]         win_cnt_o
);
    localparam int SW = DATA_W + LOG2_WIN;

    logic                 valid_q, valid_d;
    logic [SW-1:0]        sum_q, sum_d;
    logic [DATA_W-1:0]    avg_q, avg_d;
    logic [DATA_W-1:0]    max_q, max_d;
    logic [WIN_CNT_W-1:0] win_cnt_q, win_cnt_d;
    logic                 drain;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            sum_q     <= '0;
            avg_q     <= '0;
            max_q     <= '0;
            win_cnt_q <= '0;
        end else begin
            valid_q   <= valid_d;
            sum_q     <= sum_d;
            avg_q     <= avg_d;
            max_q     <= max_d;
            win_cnt_q <= win_cnt_d;
        end
    end

    // A load in the drain cycle keeps valid high so back-to-back windows have no bubble.
    always_comb begin
        drain     = valid_q && out_ready_i;
        valid_d   = load_i || (valid_q && !out_ready_i);
        sum_d     = sum_q;
        avg_d     = avg_q;
        max_d     = max_q;
        win_cnt_d = drain ? sat_inc(win_cnt_q) : win_cnt_q;
        if (load_i) begin
            sum_d = sum_i;
            avg_d = sum_i[SW-1:LOG2_WIN];
            max_d = max_i;
        end
    end

    assign out_valid_o = valid_q;
    assign out_sum_o   = sum_q;
    assign out_avg_o   = avg_q;
    assign out_max_o   = max_q;
    assign win_cnt_o   = win_cnt_q;

endmodule

// File: rtl/sum_window_avg.sv
// rtl/sum_window_avg.sv - accumulates fixed windows of sum samples into total, average and maximum
module sum_window_avg
    import sum_window_avg_pkg::*;
#(
    parameter int DATA_W   = SAMPLE_W,
    parameter int LOG2_WIN = LOG2_WIN_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    sum_window_avg_if.slave       s,
    output logic [WIN_CNT_W-1:0]  win_cnt
);
    localparam int                SW       = DATA_W + LOG2_WIN;
    localparam logic [LOG2_WIN-1:0] CNT_LAST = '1;

    logic [SW-1:0]       acc_q, acc_d;
    logic [LOG2_WIN-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0]   max_q, max_d;
    win_phase_e          phase;
    logic                accept;
    logic                load;
    logic [SW-1:0]       res_sum;
    logic [DATA_W-1:0]   res_max;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
            max_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            max_q <= max_d;
        end
    end

    assign phase = (cnt_q == CNT_LAST) ? PH_LAST : PH_FILL;

    // Only the window-completing sample can stall, and only when the held result is not leaving.
    assign s.in_ready = !clear && !(phase == PH_LAST && s.out_valid && !s.out_ready);
    assign accept     = s.in_valid && s.in_ready;

    assign res_sum = acc_q + SW'(s.in_data);
    assign res_max = (s.in_data > max_q) ? s.in_data : max_q;

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        max_d = max_q;
        load  = 1'b0;
        if (clear) begin
            acc_d = '0;
            cnt_d = '0;
            max_d = '0;
        end else if (accept) begin
            case (phase)
                PH_FILL: begin
                    acc_d = res_sum;
                    max_d = res_max;
                    cnt_d = cnt_q + 1'b1;
                end
                PH_LAST: begin
                    load  = 1'b1;
                    acc_d = '0;
                    max_d = '0;
                    cnt_d = '0;
                end
                default: ;
            endcase
        end
    end

    win_result_reg #(
        .DATA_W   (DATA_W),
        .LOG2_WIN (LOG2_WIN)
    ) u_res (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (load),
        .sum_i       (res_sum),
        .max_i       (res_max),
        .out_ready_i (s.out_ready),
        .out_valid_o (s.out_valid),
        .out_sum_o   (s.out_sum),
        .out_avg_o   (s.out_avg),
        .out_max_o   (s.out_max),
        .win_cnt_o   (win_cnt)
    );

endmodule

// File: tb/tb_sum_window_avg.sv
// tb/tb_sum_window_avg.sv - directed and random checks of the window averager against a queue model
module tb_sum_window_avg;
    localparam int DW  = 8;
    localparam int LW  = 2;
    localparam int WIN = 1 << LW;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic [15:0] win_cnt;

    always #5 clk = ~clk;

    sum_window_avg_if #(.DATA_W(DW), .LOG2_WIN(LW)) bus ();

    sum_window_avg #(.DATA_W(DW), .LOG2_WIN(LW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .s       (bus),
        .win_cnt (win_cnt)
    );

    int checks = 0;
    int errors = 0;

    int unsigned cur[$];
    bit          pend;
    int unsigned e_sum, e_avg, e_max, e_wc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        cur.delete();
        pend  = 0;
        e_sum = 0;
        e_avg = 0;
        e_max = 0;
        e_wc  = 0;
    endtask

    task automatic check_outputs();
        check("out_valid", 32'(bus.out_valid), 32'(pend));
        check("win_cnt", 32'(win_cnt), e_wc);
        if (pend) begin
            check("out_sum", 32'(bus.out_sum), e_sum);
            check("out_avg", 32'(bus.out_avg), e_avg);
            check("out_max", 32'(bus.out_max), e_max);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; clear = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        check("rst_out_sum", 32'(bus.out_sum), 0);
        check("rst_out_avg", 32'(bus.out_avg), 0);
        check("rst_out_max", 32'(bus.out_max), 0);
        check("rst_in_ready", 32'(bus.in_ready), 1);
        check_outputs();
    endtask

    // One clock: drive, check readiness, advance model on the edge, check registered outputs.
    task automatic cycle(input logic v, input logic [7:0] d, input logic r, input logic c,
                         output bit took);
        bit exp_rdy, drain;
        int unsigned s, m;
        bus.in_valid = v; bus.in_data = d; bus.out_ready = r; clear = c;
        #1;
        exp_rdy = !c && !((cur.size() == WIN - 1) && pend && !r);
        check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        took  = v && exp_rdy;
        drain = pend && r;
        @(posedge clk); #1;
        if (drain) begin
            pend = 0;
            if (e_wc < 32'hFFFF) e_wc++;
        end
        if (c) begin
            cur.delete();
        end else if (took) begin
            cur.push_back(int'(d));
            if (cur.size() == WIN) begin
                s = 0; m = 0;
                foreach (cur[i]) begin
                    s += cur[i];
                    if (cur[i] > m) m = cur[i];
                end
                e_sum = s; e_avg = s / WIN; e_max = m; pend = 1;
                cur.delete();
            end
        end
        check_outputs();
    endtask

    task automatic send(input logic [7:0] d, input logic r);
        bit took;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, d, r, 1'b0, took);
            if (took) return;
        end
        checks++;
        errors++;
        $error("FAIL send_timeout observed not_accepted expected accepted data %0d", d);
    endtask

    task automatic idle(input logic r);
        bit took;
        cycle(1'b0, 8'd0, r, 1'b0, took);
    endtask

    initial begin
        bit took;
        do_reset();

        send(8'd10, 1'b1); send(8'd20, 1'b1); send(8'd30, 1'b1); send(8'd40, 1'b1);
        check("t1_sum", 32'(bus.out_sum), 100);
        check("t1_avg", 32'(bus.out_avg), 25);
        idle(1'b1);
        check("t1_wc", 32'(win_cnt), 1);

        for (int i = 0; i < 4; i++) send(8'd255, 1'b1);
        check("t2_sum", 32'(bus.out_sum), 1020);
        send(8'd1, 1'b1); send(8'd2, 1'b1); send(8'd3, 1'b1); send(8'd3, 1'b1);
        check("t2_avg_trunc", 32'(bus.out_avg), 2);
        idle(1'b1);

        // Second window's last sample waits for the held result to drain.
        for (int i = 0; i < 7; i++) send(8'd5, 1'b0);
        cycle(1'b1, 8'd5, 1'b0, 1'b0, took);
        check("t3_stalled", 32'(took), 0);
        cycle(1'b1, 8'd5, 1'b1, 1'b0, took);
        check("t3_no_bubble", 32'(bus.out_valid), 1);
        idle(1'b1);

        send(8'd7, 1'b1); send(8'd9, 1'b1);
        cycle(1'b1, 8'd100, 1'b1, 1'b1, took);
        for (int i = 0; i < 4; i++) send(8'd1, 1'b1);
        check("t4_sum", 32'(bus.out_sum), 4);
        idle(1'b1);

        for (int i = 0; i < 4; i++) send(8'd50, 1'b0);
        for (int i = 0; i < 3; i++) send(8'd60, 1'b0);
        do_reset();
        for (int i = 0; i < 4; i++) send(8'd2, 1'b1);
        check("t5_sum", 32'(bus.out_sum), 8);
        idle(1'b1);

        for (int n = 0; n < 400; n++) begin
            cycle($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0, took);
        end

        idle(1'b1);
        force dut.u_res.win_cnt_q = 16'hFFFE;
        #1;
        release dut.u_res.win_cnt_q;
        e_wc = 32'hFFFE;
        for (int i = 0; i < 4; i++) send(8'(i * 17), 1'b1);
        idle(1'b1);
        check("sat_first", 32'(win_cnt), 32'hFFFF);
        for (int i = 0; i < 4; i++) send(8'(200 + i), 1'b1);
        idle(1'b1);
        check("sat_hold", 32'(win_cnt), 32'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sum_window_avg.md
# sum_window_avg

Downstream consumer of the registered 8-bit adder sum stream. Accumulates fixed-size windows of 2^LOG2_WIN sums and emits per-window total, truncated average and maximum over a valid/ready interface. One output register plus a free-running accumulator, so the next window accumulates while the previous result waits for the consumer.

## Interface
- DATA_W, 8, width of incoming sum samples
- LOG2_WIN, 2, log2 of window length (WIN = 4 samples); legal 1..8
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- clear  in  1  synchronous flush of the partial window (accumulator, count, max)
- in_valid  in  1  sample offered
- in_ready  out  1  sample accepted when in_valid && in_ready
- in_data  in  DATA_W  sum sample from adder stage
- out_valid  out  1  window result held
- out_ready  in  1  consumer takes result when out_valid && out_ready
- out_sum  out  DATA_W+LOG2_WIN  exact window total
- out_avg  out  DATA_W  out_sum >> LOG2_WIN (truncated)
- out_max  out  DATA_W  largest sample in window (unsigned)
- win_cnt  out  16  windows delivered to consumer, saturates at 16'hFFFF

## Operation
- Internal state: acc (DATA_W+LOG2_WIN bits, never overflows), cnt (LOG2_WIN bits, index of next sample), max_r (DATA_W), output register set.
- Window-phase FSM is cnt: FILL (cnt < WIN-1) and LAST (cnt == WIN-1).
- in_ready = !clear && !(cnt == WIN-1 && out_valid && !out_ready). Only the window-completing sample stalls; FILL samples always accepted.
- Accept in FILL: acc += in_data, max_r = max(max_r, in_data), cnt++.
- Accept in LAST: out_sum = acc + in_data, out_avg = that >> LOG2_WIN, out_max = max(max_r, in_data), out_valid = 1; acc, max_r, cnt return to 0.
- Output drain: out_valid && out_ready clears out_valid and increments win_cnt (saturating) unless a new result loads the same cycle, in which case out_valid stays 1 and win_cnt still increments.
- clear: acc, cnt, max_r to 0 next cycle; in_data ignored that cycle; pending output and win_cnt untouched.
- Unsigned arithmetic throughout; max compare unsigned; ties keep existing value.

## Timing
- Reset (rst_n low at an edge): out_valid 0, out_sum 0, out_avg 0, out_max 0, win_cnt 0, acc/cnt/max_r 0; in_ready 1 the cycle after release (combinational from state). Reset mid-window or with result pending discards everything.
- Latency: result visible with out_valid 1 the cycle after the handshake of the WIN-th sample.
- Throughput: one sample per cycle sustained when out_ready held high; back-to-back windows produce out_valid continuously with no bubble.
- Outputs out_* registered; in_ready is the only combinational output (depends on out_ready, clear, state).
- Result fields stable while out_valid && !out_ready.
- Simultaneous clear and LAST sample: clear wins, sample not accepted (in_ready 0).
- cnt wraps WIN-1 -> 0 only on LAST acceptance or clear.

## Structure
- Shared package: DATA_W default, derived widths (SUM_W = DATA_W+LOG2_WIN), WIN_CNT_W = 16 and its saturation constant, so the adder stage and this block agree on sample width.
- One natural sub-module: win_result_reg (output register with valid/ready hold, load-while-drain, win_cnt saturation). Accumulator/count/max stay in the top.

## Test plan
- After reset, in_valid samples 10,20,30,40 with out_ready 1 -> next cycle out_valid 1, out_sum 100, out_avg 25, out_max 40, then win_cnt 1.
- Four samples of 255 -> out_sum 1020, out_avg 255, out_max 255; samples 1,2,3,3 -> out_sum 9, out_avg 2 (truncation), out_max 3.
- out_ready 0, feed 8 samples of 5 -> first result (20) held; 4th sample of window 2 sees in_ready 0 until out_ready 1, then result 20 replaced by 20 in the next cycle with out_valid never dropping; win_cnt 2 after both drained.
- Samples 7,9 then clear with in_valid 1 and data 100 -> 100 rejected; then 1,1,1,1 -> out_sum 4, out_max 1.
- rst_n low for one cycle after 3 samples with a result pending -> all outputs 0, win_cnt 0; next 4 samples of 2 -> out_sum 8.
- Force win_cnt to 16'hFFFE by running windows; two more drains -> win_cnt stays 16'hFFFF.
